// File: rtl/core_pkg.sv
// Shared definitions for the core pipeline control: the hazard FSM states,
// the register-index width, and the pipeline stage indices.
package core_pkg;

  localparam int REGW = 5;

  // Stage indices. stall[i] holds the register feeding stage i.
  // flush[i] loads a bubble into that same register.
  localparam int STG_PC  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  typedef enum logic [1:0] {
    RUN,
    MD_WAIT,
    TRAP,
    REFILL
  } hc_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: the load in EX writes a register that the instruction
// in ID reads. Register x0 never creates a dependency.
module hazard_detect #(
  parameter int REGW = core_pkg::REGW
) (
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [REGW-1:0] ex_rd,
  input  logic            ex_is_load,
  output logic            load_use
);

  assign load_use = ex_is_load && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/flush control for the 5-stage pipeline. The outputs are
// combinational from the state and the inputs. The FSM tracks mul/div
// occupancy and trap refill.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int REGW         = core_pkg::REGW,
  parameter int CNTW         = 64,
  parameter int TRAP_BUBBLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [REGW-1:0] ex_rd,
  input  logic            ex_is_load,
  input  logic            ex_branch_taken,
  input  logic            ex_md_start,
  input  logic            md_done,
  output logic            md_kill,
  input  logic            mem_trap,
  input  logic            mem_mret,
  input  logic            imem_busy,
  input  logic            dmem_busy,
  output logic            stall_pc,
  output logic            stall_id,
  output logic            stall_ex,
  output logic            stall_mem,
  output logic            flush_id,
  output logic            flush_ex,
  output logic            flush_mem,
  output logic            flush_wb,
  output logic [CNTW-1:0] stall_cycles
);

  hc_state_t            state, state_nxt;
  logic [1:0]           bub_cnt, bub_nxt;
  logic                 load_use;
  logic                 redirect;
  logic                 stall_any;
  int                   stall_lvl;
  logic                 kill;
  logic [STG_MEM:STG_PC] stall_v;
  logic [STG_WB:STG_ID]  flush_v;

  hazard_detect #(.REGW(REGW)) u_detect (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_rd      (ex_rd),
    .ex_is_load (ex_is_load),
    .load_use   (load_use)
  );

  assign redirect = mem_trap | mem_mret;

  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    state_nxt = state;
    bub_nxt   = bub_cnt;
    stall_any = 1'b0;
    stall_lvl = STG_PC;
    flush_v   = '0;
    kill      = 1'b0;
    stall_v   = '0;

    unique case (state)
      RUN: begin
        if (dmem_busy) begin
          stall_any = 1'b1;
          stall_lvl = STG_MEM;
        end else if (redirect) begin
          flush_v   = '1;
          kill      = ex_md_start;
          state_nxt = TRAP;
        end else if (ex_branch_taken) begin
          flush_v[STG_ID] = 1'b1;
          flush_v[STG_EX] = 1'b1;
        end else if (ex_md_start) begin
          stall_any = 1'b1;
          stall_lvl = STG_EX;
          state_nxt = MD_WAIT;
        end else if (load_use) begin
          stall_any = 1'b1;
          stall_lvl = STG_ID;
        end else if (imem_busy) begin
          stall_any = 1'b1;
        end
      end
      MD_WAIT: begin
        if (dmem_busy) begin
          stall_any = 1'b1;
          stall_lvl = STG_MEM;
        end else if (redirect) begin
          flush_v   = '1;
          kill      = 1'b1;
          state_nxt = TRAP;
        end else if (md_done) begin
          state_nxt = RUN;
        end else begin
          stall_any = 1'b1;
          stall_lvl = STG_EX;
        end
      end
      TRAP: begin
        flush_v[STG_ID]  = 1'b1;
        flush_v[STG_EX]  = 1'b1;
        flush_v[STG_MEM] = 1'b1;
        bub_nxt          = 2'(TRAP_BUBBLES);
        state_nxt        = REFILL;
      end
      REFILL: begin
        if (redirect) begin
          flush_v   = '1;
          state_nxt = TRAP;
        end else begin
          flush_v[STG_ID] = 1'b1;
          if (imem_busy) begin
            stall_any = 1'b1;
          end else begin
            bub_nxt = bub_cnt - 2'd1;
            if (bub_cnt == 2'd1) state_nxt = RUN;
          end
        end
      end
      default: state_nxt = RUN;
    endcase

    // Stall everything up to the deepest held stage and bubble the stage after it.
    // A flush on the same register wins over a stall.
    for (int s = STG_PC; s <= STG_MEM; s++)
      if (stall_any && s <= stall_lvl) stall_v[s] = 1'b1;
    for (int s = STG_ID; s <= STG_WB; s++)
      if (stall_any && s == stall_lvl + 1) flush_v[s] = 1'b1;
    for (int s = STG_ID; s <= STG_MEM; s++)
      if (flush_v[s]) stall_v[s] = 1'b0;
  end

  assign stall_pc  = !reset && stall_v[STG_PC];
  assign stall_id  = !reset && stall_v[STG_ID];
  assign stall_ex  = !reset && stall_v[STG_EX];
  assign stall_mem = !reset && stall_v[STG_MEM];
  assign flush_id  = reset || flush_v[STG_ID];
  assign flush_ex  = reset || flush_v[STG_EX];
  assign flush_mem = reset || flush_v[STG_MEM];
  assign flush_wb  = reset || flush_v[STG_WB];
  assign md_kill   = !reset && kill;

  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with non-blocking (<=) only.
    if (reset) begin
      state        <= RUN;
      bub_cnt      <= '0;
      stall_cycles <= '0;
    end else begin
      state   <= state_nxt;
      bub_cnt <= bub_nxt;
      if (stall_pc) stall_cycles <= stall_cycles + CNTW'(1);
    end
  end

  // A taken redirect and a mul/div issue cannot come from the same EX instruction.
  a_no_branch_md: assert property (@(posedge clk) disable iff (reset)
    !(state == RUN && ex_branch_taken && ex_md_start));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. It uses a 4-bit stall counter so that the
// wrap can be reached, and two trap bubbles.
module tb_hazard_ctrl;
  import core_pkg::*;

  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [4:0]      id_rs1, id_rs2, ex_rd;
  logic            id_use_rs1, id_use_rs2, ex_is_load, ex_branch_taken;
  logic            ex_md_start, md_done, md_kill, mem_trap, mem_mret;
  logic            imem_busy, dmem_busy;
  logic            stall_pc, stall_id, stall_ex, stall_mem;
  logic            flush_id, flush_ex, flush_mem, flush_wb;
  logic [CNTW-1:0] stall_cycles;
  logic [8:0]      ctl;
  logic [3:0]      sc_exp;

  int vectors     = 0;
  int miscompares = 0;

  // ctl bit order: stall pc,id,ex,mem | flush id,ex,mem,wb | md_kill
  localparam logic [8:0] C_IDLE   = 9'b0000_0000_0;
  localparam logic [8:0] C_REDIR  = 9'b0000_1111_0;
  localparam logic [8:0] C_REDIRK = 9'b0000_1111_1;
  localparam logic [8:0] C_LU     = 9'b1100_0100_0;
  localparam logic [8:0] C_MD     = 9'b1110_0010_0;
  localparam logic [8:0] C_TRAP   = 9'b0000_1110_0;
  localparam logic [8:0] C_REFILL = 9'b0000_1000_0;
  localparam logic [8:0] C_IMEM   = 9'b1000_1000_0;
  localparam logic [8:0] C_BR     = 9'b0000_1100_0;
  localparam logic [8:0] C_DMEM   = 9'b1111_0001_0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REGW(5), .CNTW(CNTW), .TRAP_BUBBLES(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_rd           (ex_rd),
    .ex_is_load      (ex_is_load),
    .ex_branch_taken (ex_branch_taken),
    .ex_md_start     (ex_md_start),
    .md_done         (md_done),
    .md_kill         (md_kill),
    .mem_trap        (mem_trap),
    .mem_mret        (mem_mret),
    .imem_busy       (imem_busy),
    .dmem_busy       (dmem_busy),
    .stall_pc        (stall_pc),
    .stall_id        (stall_id),
    .stall_ex        (stall_ex),
    .stall_mem       (stall_mem),
    .flush_id        (flush_id),
    .flush_ex        (flush_ex),
    .flush_mem       (flush_mem),
    .flush_wb        (flush_wb),
    .stall_cycles    (stall_cycles)
  );

  assign ctl = {stall_pc, stall_id, stall_ex, stall_mem,
                flush_id, flush_ex, flush_mem, flush_wb, md_kill};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_is_load = 0; ex_branch_taken = 0;
    ex_md_start = 0; md_done = 0; mem_trap = 0; mem_mret = 0;
    imem_busy = 0; dmem_busy = 0;
  endtask

  // Advance to the next falling edge and drop every input to idle.
  task automatic next();
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    reset = 1'b1;
    imem_busy = 1'b1;

    // Reset: flushes high and stalls low, even while a stall source is present.
    @(negedge clk); #1;
    check("rst_ctl0", ctl, C_RST());
    @(negedge clk); #1;
    check("rst_ctl1", ctl, C_RST());
    check("rst_cnt", stall_cycles, 0);

    next(); reset = 1'b0; #1;
    check("rel_ctl", ctl, C_IDLE);
    check("rel_state", dut.state, RUN);
    check("rel_cnt", stall_cycles, 0);

    // Load-use on rs2.
    next(); ex_is_load = 1; ex_rd = 5; id_use_rs2 = 1; id_rs2 = 5; #1;
    check("lu_rs2", ctl, C_LU);
    next(); #1;
    check("lu_cnt", stall_cycles, 1);
    check("lu_after", ctl, C_IDLE);

    // x0 never stalls, and a matching but unused operand never stalls.
    next(); ex_is_load = 1; ex_rd = 0; id_use_rs2 = 1; id_rs2 = 0; #1;
    check("lu_x0", ctl, C_IDLE);
    next(); ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_use_rs2 = 1; id_rs2 = 6; #1;
    check("lu_unused", ctl, C_IDLE);
    next(); ex_is_load = 1; ex_rd = 7; id_use_rs1 = 1; id_rs1 = 7; #1;
    check("lu_rs1", ctl, C_LU);
    next(); #1;
    check("lu_cnt2", stall_cycles, 2);

    // Mul/div issue with md_done four cycles later.
    next(); ex_md_start = 1; #1;
    check("md_issue", ctl, C_MD);
    for (int i = 1; i <= 3; i++) begin
      next(); #1;
      check("md_wait", ctl, C_MD);
      check("md_state", dut.state, MD_WAIT);
    end
    next(); md_done = 1; #1;
    check("md_done", ctl, C_IDLE);
    next(); #1;
    check("md_ret", dut.state, RUN);
    check("md_cnt", stall_cycles, 6);

    // Mul/div interrupted two cycles after issue.
    next(); ex_md_start = 1; #1;
    check("mdi_issue", ctl, C_MD);
    next(); #1;
    check("mdi_wait", ctl, C_MD);
    next(); mem_trap = 1; #1;
    check("mdi_kill", ctl, C_REDIRK);
    next(); #1;
    check("mdi_trap_st", dut.state, TRAP);
    check("mdi_trap", ctl, C_TRAP);
    next(); #1;
    check("mdi_ref0", ctl, C_REFILL);
    next(); #1;
    check("mdi_ref1", ctl, C_REFILL);
    next(); #1;
    check("mdi_run", ctl, C_IDLE);
    check("mdi_state", dut.state, RUN);
    check("mdi_cnt", stall_cycles, 8);

    // Trap from RUN with two refill bubbles.
    next(); mem_trap = 1; #1;
    check("trap_c0", ctl, C_REDIR);
    next(); #1;
    check("trap_c1", ctl, C_TRAP);
    next(); #1;
    check("trap_c2", ctl, C_REFILL);
    next(); #1;
    check("trap_c3", ctl, C_REFILL);
    next(); #1;
    check("trap_c4", ctl, C_IDLE);
    check("trap_state", dut.state, RUN);

    // mret, with a fetch wait stretching the refill by one cycle.
    next(); mem_mret = 1; #1;
    check("mret_c0", ctl, C_REDIR);
    next(); #1;
    check("mret_c1", ctl, C_TRAP);
    next(); imem_busy = 1; #1;
    check("mret_imem", ctl, C_IMEM);
    next(); #1;
    check("mret_ref0", ctl, C_REFILL);
    next(); #1;
    check("mret_ref1", ctl, C_REFILL);
    next(); #1;
    check("mret_run", dut.state, RUN);
    check("mret_cnt", stall_cycles, 9);

    // A branch cancels a load-use stall and a fetch stall in the same cycle.
    next(); ex_branch_taken = 1; ex_is_load = 1; ex_rd = 3;
    id_use_rs1 = 1; id_rs1 = 3; imem_busy = 1; #1;
    check("br_lu", ctl, C_BR);
    next(); #1;
    check("br_cnt", stall_cycles, 9);

    // dmem_busy holds off a pending trap until it drops.
    next(); dmem_busy = 1; mem_trap = 1; #1;
    check("dm_c0", ctl, C_DMEM);
    next(); dmem_busy = 1; mem_trap = 1; #1;
    check("dm_c1", ctl, C_DMEM);
    check("dm_state", dut.state, RUN);
    next(); mem_trap = 1; #1;
    check("dm_trap", ctl, C_REDIR);
    next(); #1;
    check("dm_trap_st", dut.state, TRAP);
    next(); next(); next(); #1;
    check("dm_run", dut.state, RUN);
    check("dm_cnt", stall_cycles, 11);

    // A fetch wait alone stalls the PC. Run the counter through its wrap.
    next(); imem_busy = 1; #1;
    check("imem_ctl", ctl, C_IMEM);
    for (int i = 0; i < 4; i++) begin
      next(); imem_busy = 1; #1;
      sc_exp = 4'(12 + i);
      check("wrap_cnt", stall_cycles, sc_exp);
    end
    next(); #1;
    check("wrap_zero", stall_cycles, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  function automatic logic [8:0] C_RST();
    return 9'b0000_1111_0;
  endfunction

endmodule
